// File: rtl/mcast_xbus_pkg.sv
// mcast_xbus shared types and constants.
// BCAST_TAG is only consulted when MCAST_XBUS_BCAST_EN is defined.
package mcast_xbus_pkg;

  localparam int MISS_CNT_W = 16;

  localparam logic [31:0] BCAST_TAG = '1;

  typedef enum logic [1:0] {
    BUSY,
    IDLE,
    ISSUE
  } state_t;

endpackage

// File: rtl/mcast_xbus_if.sv
// Input port and PE array port of the multicast row bus.
// master drives words in and PE readies; slave is the bus.
interface mcast_xbus_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int TAG_WIDTH  = 4
) ();

  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_WIDTH-1:0]         in_data;
  logic [TAG_WIDTH-1:0]          in_row_tag;
  logic [TAG_WIDTH-1:0]          in_col_tag;
  logic [NUM_ROW*NUM_COL-1:0]    pe_valid;
  logic [NUM_ROW*NUM_COL-1:0]    pe_ready;
  logic [NUM_ROW*DATA_WIDTH-1:0] pe_data;

  modport master (
    output in_valid, in_data,
    output in_row_tag, in_col_tag,
    output pe_ready,
    input  in_ready, pe_valid, pe_data
  );

  modport slave (
    input  in_valid, in_data,
    input  in_row_tag, in_col_tag,
    input  pe_ready,
    output in_ready, pe_valid, pe_data
  );

endinterface

// File: rtl/mcast_xbus_tag_match.sv
// Per-row tag compare producing the NUM_COL target mask.
// MCAST_XBUS_BCAST_EN: all-ones tag matches any ID.
module mcast_xbus_tag_match #(
  parameter int NUM_COL   = 4,
  parameter int TAG_WIDTH = 4
) (
  input  logic [TAG_WIDTH-1:0]         row_id,
  input  logic [NUM_COL*TAG_WIDTH-1:0] col_id,
  input  logic [TAG_WIDTH-1:0]         row_tag,
  input  logic [TAG_WIDTH-1:0]         col_tag,
  output logic [NUM_COL-1:0]           hit
);

  logic               row_hit;
  logic [NUM_COL-1:0] col_hit;

`ifdef MCAST_XBUS_BCAST_EN
  import mcast_xbus_pkg::*;

  localparam logic [TAG_WIDTH-1:0] BC =
    TAG_WIDTH'(BCAST_TAG);

  assign row_hit = (row_id == row_tag) |
                   (row_tag == BC);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    assign col_hit[c] =
      (col_id[c*TAG_WIDTH +: TAG_WIDTH] == col_tag) |
      (col_tag == BC);
  end
`else
  assign row_hit = (row_id == row_tag);

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    assign col_hit[c] =
      (col_id[c*TAG_WIDTH +: TAG_WIDTH] == col_tag);
  end
`endif

  assign hit = {NUM_COL{row_hit}} & col_hit;

endmodule

// File: rtl/mcast_xbus.sv
// Multicast row bus: tag-matched delivery to the PE array.
// Optional broadcast tag via MCAST_XBUS_BCAST_EN.
module mcast_xbus
  import mcast_xbus_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_ROW    = 4,
  parameter int NUM_COL    = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int RST_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  output logic                       rst_busy,
  input  logic                       cfg_we,
  input  logic                       cfg_sel,
  input  logic [$clog2(NUM_ROW)-1:0] cfg_row,
  input  logic [$clog2(NUM_COL)-1:0] cfg_col,
  input  logic [TAG_WIDTH-1:0]       cfg_tag,
  mcast_xbus_if.slave                bus,
  output logic [MISS_CNT_W-1:0]      miss_cnt
);

  localparam int NPE = NUM_ROW * NUM_COL;
  localparam int CW  = $clog2(RST_CYCLES + 1);
  localparam int TW  = TAG_WIDTH;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [NPE-1:0]          pv;
  logic [NPE-1:0]          hit;
  logic                    done_all;
  logic                    acc;

  logic [TW-1:0]         row_id [NUM_ROW];
  logic [NUM_COL*TW-1:0] col_id [NUM_ROW];

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    mcast_xbus_tag_match #(
      .NUM_COL   (NUM_COL),
      .TAG_WIDTH (TAG_WIDTH)
    ) u_match (
      .row_id  (row_id[r]),
      .col_id  (col_id[r]),
      .row_tag (bus.in_row_tag),
      .col_tag (bus.in_col_tag),
      .hit     (hit[r*NUM_COL +: NUM_COL])
    );
  end

  // pv holds mask & ~done: a bit clears on its handshake
  assign done_all = (state == ISSUE) &&
                    ((pv & ~bus.pe_ready) == '0);
  assign bus.in_ready = ((state == IDLE) || done_all) &&
                        !flush;
  assign acc          = bus.in_valid && bus.in_ready;
  assign bus.pe_valid = pv;
  assign bus.pe_data  = {NUM_ROW{data_q}};
  assign rst_busy     = (state == BUSY);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NUM_ROW; r++) begin
        row_id[r] <= TW'(r);
        for (int c = 0; c < NUM_COL; c++)
          col_id[r][c*TW +: TW] <= TW'(c);
      end
    end else if (cfg_we) begin
      if (cfg_sel)
        col_id[cfg_row][cfg_col*TW +: TW] <= cfg_tag;
      else
        row_id[cfg_row] <= cfg_tag;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= BUSY;
      cnt      <= '0;
      pv       <= '0;
      data_q   <= '0;
      miss_cnt <= '0;
    end else if (flush) begin
      state <= BUSY;
      cnt   <= '0;
      pv    <= '0;
    end else begin
      unique case (state)
        BUSY: begin
          if (cnt == CW'(RST_CYCLES - 1))
            state <= IDLE;
          else
            cnt <= cnt + CW'(1);
        end
        IDLE, ISSUE: begin
          pv <= pv & ~bus.pe_ready;
          if (done_all)
            state <= IDLE;
          if (acc) begin
            if (|hit) begin
              pv     <= hit;
              data_q <= bus.in_data;
              state  <= ISSUE;
            end else if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + MISS_CNT_W'(1);
            end
          end
        end
        default: state <= BUSY;
      endcase
    end
  end

endmodule

// File: tb/tb_mcast_xbus.sv
// Directed bench for mcast_xbus.
// Broadcast expectations follow MCAST_XBUS_BCAST_EN.
module tb_mcast_xbus;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        rst_busy;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [1:0]  cfg_row = '0;
  logic [1:0]  cfg_col = '0;
  logic [3:0]  cfg_tag = '0;
  logic [15:0] miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  mcast_xbus_if #(
    .DATA_WIDTH (16),
    .NUM_ROW    (4),
    .NUM_COL    (4),
    .TAG_WIDTH  (4)
  ) bus ();

  mcast_xbus #(
    .DATA_WIDTH (16),
    .NUM_ROW    (4),
    .NUM_COL    (4),
    .TAG_WIDTH  (4),
    .RST_CYCLES (4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .rst_busy (rst_busy),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_row  (cfg_row),
    .cfg_col  (cfg_col),
    .cfg_tag  (cfg_tag),
    .bus      (bus),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] rt,
                      input logic [3:0] ct,
                      input logic [15:0] d);
    bus.in_valid   = 1'b1;
    bus.in_row_tag = rt;
    bus.in_col_tag = ct;
    bus.in_data    = d;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_row_tag = '0;
    bus.in_col_tag = '0;
    bus.pe_ready   = '0;

    #12;
    chk("rst_busy", rst_busy, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_pe_valid", bus.pe_valid, 0);
    chk("rst_pe_data", bus.pe_data, 0);
    chk("rst_miss", miss_cnt, 0);

    // release: cycle 0 starts now
    rstn = 1'b1;
    #1;
    chk("busy_c0", rst_busy, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("busy_cn", rst_busy, 1);
      chk("busy_rdy", bus.in_ready, 0);
      chk("busy_pv", bus.pe_valid, 0);
    end
    step();
    chk("c4_busy", rst_busy, 0);
    chk("c4_rdy", bus.in_ready, 1);

    // single-target unicast
    bus.pe_ready = 16'hFFFF;
    send(4'd2, 4'd1, 16'hBEEF);
    step();
    bus.in_valid = 1'b0;
    chk("uni_pv", bus.pe_valid, 16'h0200);
    chk("uni_data2", bus.pe_data[47:32], 16'hBEEF);
    chk("uni_rdy", bus.in_ready, 1);
    step();
    chk("uni_pv_drop", bus.pe_valid, 0);

    // row 0 col IDs -> 5
    for (int c = 0; c < 4; c++) begin
      cfg_we  = 1'b1;
      cfg_sel = 1'b1;
      cfg_row = 2'd0;
      cfg_col = 2'(c);
      cfg_tag = 4'd5;
      step();
    end
    cfg_we = 1'b0;
    bus.pe_ready = 16'hFFFD;
    send(4'd0, 4'd5, 16'h1234);
    step();
    bus.in_valid = 1'b0;
    chk("mc_pv1", bus.pe_valid, 16'h000F);
    chk("mc_rdy1", bus.in_ready, 0);
    step();
    chk("mc_pv2", bus.pe_valid, 16'h0002);
    chk("mc_rdy2", bus.in_ready, 0);
    step();
    chk("mc_pv3", bus.pe_valid, 16'h0002);
    chk("mc_data3", bus.pe_data[15:0], 16'h1234);
    step();
    bus.pe_ready = 16'hFFFF;
    #1;
    chk("mc_pv4", bus.pe_valid, 16'h0002);
    chk("mc_rdy4", bus.in_ready, 1);
    step();
    chk("mc_pv5", bus.pe_valid, 0);

    // three misses back to back
    send(4'd7, 4'd0, 16'h0BAD);
    for (int i = 0; i < 3; i++) begin
      chk("miss_rdy", bus.in_ready, 1);
      step();
      chk("miss_pv", bus.pe_valid, 0);
    end
    bus.in_valid = 1'b0;
    chk("miss_cnt3", miss_cnt, 3);

    // cfg write + accept: old row ID used
    cfg_we  = 1'b1;
    cfg_sel = 1'b0;
    cfg_row = 2'd3;
    cfg_tag = 4'd6;
    send(4'd3, 4'd0, 16'hA5A5);
    step();
    cfg_we = 1'b0;
    chk("cfgacc_pv", bus.pe_valid, 16'h1000);
    chk("cfgacc_rdy", bus.in_ready, 1);
    send(4'd6, 4'd0, 16'h5A5A);
    step();
    bus.in_valid = 1'b0;
    chk("b2b_pv", bus.pe_valid, 16'h1000);
    chk("b2b_data", bus.pe_data[63:48], 16'h5A5A);
    step();
    chk("b2b_end", bus.pe_valid, 0);
    chk("b2b_miss", miss_cnt, 3);

    // flush mid-issue, flush beats in_valid
    bus.pe_ready = '0;
    send(4'd2, 4'd1, 16'hC0DE);
    step();
    bus.in_valid = 1'b0;
    chk("fl_pv", bus.pe_valid, 16'h0200);
    flush = 1'b1;
    send(4'd7, 4'd7, 16'h0000);
    #1;
    chk("fl_rdy", bus.in_ready, 0);
    step();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_pv0", bus.pe_valid, 0);
    chk("fl_busy0", rst_busy, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("fl_busyn", rst_busy, 1);
    end
    step();
    chk("fl_done", rst_busy, 0);
    chk("fl_miss", miss_cnt, 3);
    bus.pe_ready = 16'hFFFF;
    send(4'd2, 4'd1, 16'h7777);
    step();
    bus.in_valid = 1'b0;
    chk("fl_ids", bus.pe_valid, 16'h0200);
    step();

    // all-ones tags
    send(4'hF, 4'hF, 16'hFACE);
    step();
    bus.in_valid = 1'b0;
`ifdef MCAST_XBUS_BCAST_EN
    chk("bc_pv", bus.pe_valid, 16'hFFFF);
    chk("bc_miss", miss_cnt, 3);
`else
    chk("bc_pv", bus.pe_valid, 0);
    chk("bc_miss", miss_cnt, 4);
`endif
    step();

    // async reset mid-issue
    bus.pe_ready = '0;
    send(4'd1, 4'd3, 16'h4321);
    step();
    bus.in_valid = 1'b0;
    chk("ar_pv", bus.pe_valid, 16'h0080);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_pv0", bus.pe_valid, 0);
    chk("ar_data", bus.pe_data, 0);
    chk("ar_busy", rst_busy, 1);
    chk("ar_rdy", bus.in_ready, 0);
    chk("ar_miss", miss_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
